// File: rtl/brick_field_drawer_if.sv
// Brick-collision query port between the ball logic (master) and the
// brick field drawer (slave). A query is a hit_req strobe with a pixel
// coordinate; the drawer answers with a hit_done pulse and hit_brick.
interface brick_field_drawer_if;
  logic       hit_req;
  logic [9:0] hit_x;
  logic [8:0] hit_y;
  logic       hit_busy;
  logic       hit_done;
  logic       hit_brick;

  modport master (
    output hit_req, hit_x, hit_y,
    input  hit_busy, hit_done, hit_brick
  );

  modport slave (
    input  hit_req, hit_x, hit_y,
    output hit_busy, hit_done, hit_brick
  );
endinterface

// File: rtl/brick_field_drawer.sv
// Brick field drawer: renders an R x C brick field inside the playfield
// border, owns the brick present bits and answers collision queries.
// Raster position inside the field is tracked with counters, the query
// path divides by repeated subtraction, so no divider is built.
// Optional: define BRICK_OUTLINE_EN to draw a dark one-pixel outline
// around every present brick; without it bricks are solid colour.
module brick_field_drawer #(
  parameter int unsigned BORDER_WIDTH   = 8,
  parameter int unsigned BLOCK_WIDTH    = 48,
  parameter int unsigned BLOCK_HEIGHT   = 16,
  parameter int unsigned BLOCKS_PER_ROW = 13,
  parameter int unsigned NUM_ROWS       = 4,
  parameter logic [5:0]  ROW_COLOR_0    = 6'b110000,
  parameter logic [5:0]  ROW_COLOR_1    = 6'b111000,
  parameter logic [5:0]  ROW_COLOR_2    = 6'b001100,
  parameter logic [5:0]  ROW_COLOR_3    = 6'b000011
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic [9:0]                 hpos,
  input  logic [8:0]                 vpos,
  input  logic                       new_frame,
  input  logic                       new_line,
  input  logic                       level_load,
  brick_field_drawer_if.slave        hit,
  output logic                       block_en,
  output logic [5:0]                 color,
  output logic [7:0]                 blocks_left,
  output logic                       all_clear
);

  localparam int unsigned NUM_BRICKS = NUM_ROWS * BLOCKS_PER_ROW;
  localparam logic [10:0] X_LO       = 11'(BORDER_WIDTH);
  localparam logic [10:0] X_HI       = 11'(BORDER_WIDTH + BLOCKS_PER_ROW * BLOCK_WIDTH);
  localparam logic [9:0]  Y_LO       = 10'(BORDER_WIDTH);
  localparam logic [9:0]  Y_HI       = 10'(BORDER_WIDTH + NUM_ROWS * BLOCK_HEIGHT);
  localparam logic [9:0]  BORDER_X   = 10'(BORDER_WIDTH);
  localparam logic [8:0]  BORDER_Y   = 9'(BORDER_WIDTH);
  localparam logic [9:0]  BW         = 10'(BLOCK_WIDTH);
  localparam logic [9:0]  PIX_LAST   = 10'(BLOCK_WIDTH - 1);
  localparam logic [8:0]  BH         = 9'(BLOCK_HEIGHT);
  localparam logic [8:0]  LINE_LAST  = 9'(BLOCK_HEIGHT - 1);
  localparam logic [7:0]  COLS       = 8'(BLOCKS_PER_ROW);
  localparam logic [7:0]  BRICK_CNT  = 8'(NUM_BRICKS);
  // Brick bits live in a 256-bit vector so an 8-bit index always fits;
  // bits above NUM_BRICKS stay zero.
  localparam logic [255:0] FULL_MASK = (256'd1 << NUM_BRICKS) - 256'd1;

  typedef enum logic [2:0] {S_IDLE, S_DIVX, S_DIVY, S_CHECK, S_DONE} hit_state_t;

  // Raster tracking
  logic [9:0] pix_reg;
  logic [4:0] col_reg;
  logic [8:0] line_reg;
  logic [3:0] row_reg;
  logic       v_started_reg;
  logic       v_in_reg;
  logic       h_in;
  logic       v_in_now;

  // Brick state and query path
  hit_state_t   st_reg;
  logic [255:0] state_reg;
  logic [7:0]   left_reg;
  logic [9:0]   qx_reg;
  logic [8:0]   qy_reg;
  logic [4:0]   qcol_reg;
  logic [3:0]   qrow_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         brick_reg;
  logic         q_in_field;
  logic [7:0]   q_idx;

  // Draw path
  logic [7:0] draw_idx;
  logic [5:0] row_color;
  logic [5:0] brick_color;

  assign h_in       = ({1'b0, hpos} >= X_LO) && ({1'b0, hpos} < X_HI);
  assign v_in_now   = ({1'b0, vpos} >= Y_LO) && ({1'b0, vpos} < Y_HI);
  assign q_in_field = ({1'b0, hit.hit_x} >= X_LO) && ({1'b0, hit.hit_x} < X_HI) &&
                      ({1'b0, hit.hit_y} >= Y_LO) && ({1'b0, hit.hit_y} < Y_HI);
  assign q_idx      = {4'd0, qrow_reg} * COLS + {3'd0, qcol_reg};
  assign draw_idx   = {4'd0, row_reg} * COLS + {3'd0, col_reg};

  // Track brick row/line vertically and brick column/pixel horizontally
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pix_reg       <= '0;
      col_reg       <= '0;
      line_reg      <= '0;
      row_reg       <= '0;
      v_started_reg <= 1'b0;
      v_in_reg      <= 1'b0;
    end else begin
      // The first in-field line of a frame is line 0 of row 0; later
      // in-field lines advance the counters.
      if (new_frame) begin
        row_reg       <= '0;
        line_reg      <= '0;
        v_started_reg <= new_line & v_in_now;
      end else if (new_line && v_in_now) begin
        if (!v_started_reg) begin
          v_started_reg <= 1'b1;
        end else if (line_reg == LINE_LAST) begin
          line_reg <= '0;
          row_reg  <= row_reg + 4'd1;
        end else begin
          line_reg <= line_reg + 9'd1;
        end
      end
      if (new_line) begin
        pix_reg  <= '0;
        col_reg  <= '0;
        v_in_reg <= v_in_now;
      end else if (h_in) begin
        if (pix_reg == PIX_LAST) begin
          pix_reg <= '0;
          col_reg <= col_reg + 5'd1;
        end else begin
          pix_reg <= pix_reg + 10'd1;
        end
      end
    end
  end

  // Row colour cycles every four rows
  always_comb begin
    row_color = ROW_COLOR_0;
    case (row_reg[1:0])
      2'd0: row_color = ROW_COLOR_0;
      2'd1: row_color = ROW_COLOR_1;
      2'd2: row_color = ROW_COLOR_2;
      2'd3: row_color = ROW_COLOR_3;
      default: row_color = ROW_COLOR_0;
    endcase
  end

`ifdef BRICK_OUTLINE_EN
  logic on_edge;
  assign on_edge     = (pix_reg == 10'd0) || (pix_reg == PIX_LAST) ||
                       (line_reg == 9'd0) || (line_reg == LINE_LAST);
  assign brick_color = on_edge ? 6'b000000 : row_color;
`else
  assign brick_color = row_color;
`endif

  // Register the pixel output one clk behind hpos
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      block_en <= 1'b0;
      color    <= '0;
    end else if (h_in && v_in_reg && state_reg[draw_idx]) begin
      block_en <= 1'b1;
      color    <= brick_color;
    end else begin
      block_en <= 1'b0;
      color    <= '0;
    end
  end

  // Query FSM; also owns the brick bits so level_load and a clear never race
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      st_reg    <= S_IDLE;
      state_reg <= FULL_MASK;
      left_reg  <= BRICK_CNT;
      qx_reg    <= '0;
      qy_reg    <= '0;
      qcol_reg  <= '0;
      qrow_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      brick_reg <= 1'b0;
    end else if (level_load) begin
      st_reg    <= S_IDLE;
      state_reg <= FULL_MASK;
      left_reg  <= BRICK_CNT;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      brick_reg <= 1'b0;
    end else begin
      case (st_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (hit.hit_req) begin
            busy_reg  <= 1'b1;
            brick_reg <= 1'b0;
            qcol_reg  <= '0;
            qrow_reg  <= '0;
            qx_reg    <= hit.hit_x - BORDER_X;
            qy_reg    <= hit.hit_y - BORDER_Y;
            if (q_in_field) begin
              st_reg <= S_DIVX;
            end else begin
              done_reg <= 1'b1;
              st_reg   <= S_DONE;
            end
          end
        end
        S_DIVX: begin
          if (qx_reg >= BW) begin
            qx_reg   <= qx_reg - BW;
            qcol_reg <= qcol_reg + 5'd1;
          end else begin
            st_reg <= S_DIVY;
          end
        end
        S_DIVY: begin
          if (qy_reg >= BH) begin
            qy_reg   <= qy_reg - BH;
            qrow_reg <= qrow_reg + 4'd1;
          end else begin
            st_reg <= S_CHECK;
          end
        end
        S_CHECK: begin
          brick_reg <= state_reg[q_idx];
          done_reg  <= 1'b1;
          if (state_reg[q_idx]) begin
            state_reg[q_idx] <= 1'b0;
            left_reg         <= left_reg - 8'd1;
          end
          st_reg <= S_DONE;
        end
        S_DONE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          st_reg   <= S_IDLE;
        end
        default: st_reg <= S_IDLE;
      endcase
    end
  end

  assign hit.hit_busy  = busy_reg;
  assign hit.hit_done  = done_reg;
  assign hit.hit_brick = brick_reg;
  assign blocks_left   = left_reg;
  assign all_clear     = (left_reg == 8'd0);

endmodule

// File: tb/tb_brick_field_drawer.sv
// Directed bench for brick_field_drawer with default parameters.
// Expected pixel colours follow BRICK_OUTLINE_EN when it is defined.
module tb_brick_field_drawer;

  logic       clk = 1'b0;
  logic       nRst;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       new_frame;
  logic       new_line;
  logic       level_load;
  logic       block_en;
  logic [5:0] color;
  logic [7:0] blocks_left;
  logic       all_clear;

  brick_field_drawer_if hit_bus ();

  brick_field_drawer dut (
    .clk        (clk),
    .nRst       (nRst),
    .hpos       (hpos),
    .vpos       (vpos),
    .new_frame  (new_frame),
    .new_line   (new_line),
    .level_load (level_load),
    .hit        (hit_bus.slave),
    .block_en   (block_en),
    .color      (color),
    .blocks_left(blocks_left),
    .all_clear  (all_clear)
  );

  always #5 clk = ~clk;

`ifdef BRICK_OUTLINE_EN
  localparam int EDGE_COLOR_R0 = 0;
  localparam int EDGE_COLOR_R1 = 0;
`else
  localparam int EDGE_COLOR_R0 = 6'b110000;
  localparam int EDGE_COLOR_R1 = 6'b111000;
`endif

  int   n_pass  = 0;
  int   n_total = 0;
  logic       en_line  [0:640];
  logic [5:0] col_line [0:640];

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One raster line; with sweep, hpos runs 0..640 and outputs are captured
  task automatic raster_line(input int v, input bit sweep);
    vpos     = 9'(v);
    hpos     = 10'd0;
    new_line = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
    if (sweep) begin
      for (int h = 0; h <= 640; h++) begin
        hpos = 10'(h);
        @(negedge clk);
        en_line[h]  = block_en;
        col_line[h] = color;
      end
      hpos = 10'd0;
      $display("line vpos=%0d swept", v);
    end
  endtask

  // New frame, skip lines quickly, then sweep line v
  task automatic sweep_line(input int v);
    new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    for (int i = 0; i < v; i++) raster_line(i, 1'b0);
    raster_line(v, 1'b1);
  endtask

  function automatic int count_en(input int lo, input int hi);
    int n = 0;
    for (int h = lo; h <= hi; h++) if (en_line[h]) n++;
    return n;
  endfunction

  task automatic query(input int x, input int y, output bit hit, output int lat, output bit ok);
    hit_bus.hit_x   = 10'(x);
    hit_bus.hit_y   = 9'(y);
    hit_bus.hit_req = 1'b1;
    ok  = 1'b0;
    lat = 0;
    hit = 1'b0;
    for (int i = 1; i <= 40 && !ok; i++) begin
      @(negedge clk);
      hit_bus.hit_req = 1'b0;
      if (hit_bus.hit_done) begin
        ok  = 1'b1;
        lat = i;
        hit = hit_bus.hit_brick;
      end
    end
    @(negedge clk);
    $display("query (%0d,%0d): done=%0d hit=%0d latency=%0d blocks_left=%0d",
             x, y, ok, hit, lat, blocks_left);
  endtask

  task automatic pulse_load();
    level_load = 1'b1;
    @(negedge clk);
    level_load = 1'b0;
  endtask

  bit hit;
  bit ok;
  int lat;
  int dones;
  int hits;

  initial begin
    nRst = 1'b0; hpos = '0; vpos = '0; new_frame = 1'b0; new_line = 1'b0; level_load = 1'b0;
    hit_bus.hit_req = 1'b0; hit_bus.hit_x = '0; hit_bus.hit_y = '0;
    repeat (2) @(negedge clk);
    check("rst_block_en", block_en, 0);
    check("rst_color", color, 0);
    check("rst_busy", hit_bus.hit_busy, 0);
    check("rst_done", hit_bus.hit_done, 0);
    check("rst_brick", hit_bus.hit_brick, 0);
    check("rst_blocks_left", blocks_left, 52);
    check("rst_all_clear", all_clear, 0);
    nRst = 1'b1;
    @(negedge clk);

    // Field extent and row colours
    sweep_line(8);
    check("v8_en_count_8_631", count_en(8, 631), 624);
    check("v8_en_h7", en_line[7], 0);
    check("v8_en_h632", en_line[632], 0);
    check("v8_color_h8", col_line[8], EDGE_COLOR_R0);
    sweep_line(9);
    check("v9_en_h8", en_line[8], 1);
    check("v9_color_h8", col_line[8], EDGE_COLOR_R0);
    check("v9_color_h55", col_line[55], EDGE_COLOR_R0);
    check("v9_color_h9", col_line[9], 6'b110000);
    sweep_line(24);
    check("v24_color_h100", col_line[100], EDGE_COLOR_R1);
    sweep_line(25);
    check("v25_color_h100", col_line[100], 6'b111000);
    check("v25_en_h100", en_line[100], 1);

    // First hit clears brick 1
    query(60, 10, hit, lat, ok);
    check("q1_done", ok, 1);
    check("q1_hit", hit, 1);
    check("q1_latency_le20", (lat <= 20) ? 1 : 0, 1);
    check("q1_blocks_left", blocks_left, 51);
    sweep_line(8);
    check("v8_cleared_56_103", count_en(56, 103), 0);
    check("v8_neighbour_h55", en_line[55], 1);
    check("v8_neighbour_h104", en_line[104], 1);

    query(60, 10, hit, lat, ok);
    check("q2_done", ok, 1);
    check("q2_hit", hit, 0);
    check("q2_blocks_left", blocks_left, 51);

    query(4, 4, hit, lat, ok);
    check("border_done", ok, 1);
    check("border_latency", (lat <= 2) ? 1 : 0, 1);
    check("border_hit", hit, 0);
    check("border_blocks_left", blocks_left, 51);

    // Long query on brick 51 with a second request while busy
    hit_bus.hit_x = 10'd589; hit_bus.hit_y = 9'd59; hit_bus.hit_req = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hit_bus.hit_done) dones++;
      if (i == 1) begin
        check("busy_flag", hit_bus.hit_busy, 1);
        hit_bus.hit_x = 10'd60; hit_bus.hit_y = 9'd26; hit_bus.hit_req = 1'b1;
      end else begin
        hit_bus.hit_req = 1'b0;
      end
    end
    $display("busy-overlap query (589,59): dones=%0d blocks_left=%0d", dones, blocks_left);
    check("busy_single_done", dones, 1);
    check("busy_blocks_left", blocks_left, 50);
    query(60, 26, hit, lat, ok);
    check("ignored_req_brick_kept", hit, 1);
    check("q14_blocks_left", blocks_left, 49);

    // Clear everything
    hits = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 13; c++) begin
        query(8 + c * 48 + 1, 8 + r * 16 + 1, hit, lat, ok);
        if (!ok) check("clear_timeout", 0, 1);
        if (hit) hits++;
      end
    check("clear_hits", hits, 49);
    check("clear_blocks_left", blocks_left, 0);
    check("clear_all_clear", all_clear, 1);
    query(100, 30, hit, lat, ok);
    check("empty_hit", hit, 0);
    check("empty_no_underflow", blocks_left, 0);

    pulse_load();
    $display("level_load: blocks_left=%0d all_clear=%0d", blocks_left, all_clear);
    check("load_blocks_left", blocks_left, 52);
    check("load_all_clear", all_clear, 0);

    // level_load landing at each point of an in-flight query
    for (int k = 2; k <= 7; k++) begin
      hit_bus.hit_x = 10'd60; hit_bus.hit_y = 9'd10; hit_bus.hit_req = 1'b1;
      for (int i = 1; i < k; i++) begin
        @(negedge clk);
        hit_bus.hit_req = 1'b0;
      end
      level_load = 1'b1;
      @(negedge clk);
      level_load = 1'b0;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
        if (hit_bus.hit_done) dones++;
        @(negedge clk);
      end
      $display("load at offset %0d: dones=%0d blocks_left=%0d", k, dones, blocks_left);
      if (k == 2) check("load_abort_no_done", dones, 0);
      check($sformatf("load_k%0d_blocks_left", k), blocks_left, 52);
      check($sformatf("load_k%0d_busy", k), hit_bus.hit_busy, 0);
      query(60, 10, hit, lat, ok);
      check($sformatf("load_k%0d_brick_present", k), hit, 1);
      pulse_load();
    end

    // Reset in the middle of a query
    query(60, 10, hit, lat, ok);
    hit_bus.hit_x = 10'd589; hit_bus.hit_y = 9'd59; hit_bus.hit_req = 1'b1;
    @(negedge clk);
    hit_bus.hit_req = 1'b0;
    @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    check("midrst_busy", hit_bus.hit_busy, 0);
    check("midrst_blocks_left", blocks_left, 52);
    nRst = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_stays_idle", hit_bus.hit_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
